lpif_txrx_flit_serdes: RTL

- Parametrised successor to the fixed x16 LPIF master packer. Packs the downstream LPIF flit fields into a link word, and unpacks the upstream link word back into the same fields.
- Adds valid/ready handshakes on both the user side and the FIFO side, with one holding register per direction.
- Adds a Gen1 half-rate mode. In Gen1 each flit crosses the link as two beats (low half, then high half) and is reassembled on receive.
- Sits between the LPIF adapter and the logic-link TX/RX FIFOs.

---
 rtl/lpif_txrx_flit_serdes.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_flit_serdes.sv
// LPIF flit pack/unpack between the adapter and the logic-link FIFOs, Gen1 two-beat or Gen2 full-word.
// Define LPIF_TXRX_PARITY_EN to add even parity on link beats and a sticky RX parity error.
module lpif_txrx_flit_serdes #(
    parameter  int DATA_BYTES = 128,
    localparam int BSTART_W   = $clog2(DATA_BYTES),
    localparam int W          = 4 + 2 + 8*DATA_BYTES + BSTART_W + DATA_BYTES + 1,
    localparam int HALF_W     = (W + 1) / 2
) (
    input  logic                    lclk,
    input  logic                    lrst,
    input  logic                    m_gen2_mode,

    input  logic [3:0]              dstrm_state,
    input  logic [1:0]              dstrm_protid,
    input  logic [8*DATA_BYTES-1:0] dstrm_data,
    input  logic [BSTART_W-1:0]     dstrm_bstart,
    input  logic [DATA_BYTES-1:0]   dstrm_bvalid,
    input  logic                    dstrm_valid,
    input  logic                    user_downstream_valid,
    output logic                    user_downstream_ready,

    output logic [3:0]              ustrm_state,
    output logic [1:0]              ustrm_protid,
    output logic [8*DATA_BYTES-1:0] ustrm_data,
    output logic [BSTART_W-1:0]     ustrm_bstart,
    output logic [DATA_BYTES-1:0]   ustrm_bvalid,
    output logic                    ustrm_valid,
    output logic                    user_upstream_valid,
    input  logic                    user_upstream_ready,

`ifdef LPIF_TXRX_PARITY_EN
    output logic                    txfifo_downstream_par,
    input  logic                    rxfifo_upstream_par,
    output logic                    rx_parity_err,
`endif

    output logic [W-1:0]            txfifo_downstream_data,
    output logic                    txfifo_downstream_valid,
    input  logic                    txfifo_downstream_ready,

    input  logic [W-1:0]            rxfifo_upstream_data,
    input  logic                    rxfifo_upstream_valid,
    output logic                    rxfifo_upstream_ready
);

    localparam int DATA_LSB = 6;
    localparam int BST_LSB  = DATA_LSB + 8*DATA_BYTES;
    localparam int BV_LSB   = BST_LSB + BSTART_W;
    localparam int HI_W     = W - HALF_W;

    typedef enum logic [1:0] {TX_IDLE, TX_FULL, TX_LO, TX_HI} tx_state_e;
    typedef enum logic       {RX_LO, RX_HI} rx_state_e;

    // ---------------- TX ----------------
    tx_state_e      tx_state;
    logic [W-1:0]   tx_word_q;
    logic           tx_mode_q;
    logic [W-1:0]   tx_pack;
    logic           tx_fire;
    logic           tx_last;
    logic           tx_accept;

    assign tx_pack = {dstrm_valid, dstrm_bvalid, dstrm_bstart,
                      dstrm_data, dstrm_protid, dstrm_state};

    assign txfifo_downstream_valid = (tx_state != TX_IDLE);
    assign tx_fire   = txfifo_downstream_valid & txfifo_downstream_ready;
    assign tx_last   = tx_fire & (tx_mode_q ? (tx_state == TX_FULL)
                                            : (tx_state == TX_HI));
    assign user_downstream_ready = !lrst & ((tx_state == TX_IDLE) | tx_last);
    assign tx_accept = user_downstream_valid & user_downstream_ready;

    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst) begin
            tx_state  <= TX_IDLE;
            tx_word_q <= '0;
            tx_mode_q <= 1'b0;
        end else if (tx_accept) begin
            tx_word_q <= tx_pack;
            tx_mode_q <= m_gen2_mode;
            tx_state  <= m_gen2_mode ? TX_FULL : TX_LO;
        end else begin
            unique case (tx_state)
                TX_LO:          if (tx_fire) tx_state <= TX_HI;
                TX_FULL, TX_HI: if (tx_last) tx_state <= TX_IDLE;
                default:        ;
            endcase
        end
    end

    // Gen1 halves ride in the low bits of the link word, upper bits zero.
    always_comb begin
        txfifo_downstream_data = '0;
        unique case (tx_state)
            TX_FULL: txfifo_downstream_data = tx_word_q;
            TX_LO:   txfifo_downstream_data = {{HI_W{1'b0}}, tx_word_q[HALF_W-1:0]};
            TX_HI:   txfifo_downstream_data = {{HALF_W{1'b0}}, tx_word_q[W-1:HALF_W]};
            default: ;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e          rx_state;
    logic [HALF_W-1:0]  rx_lo_q;
    logic [W-1:0]       rx_out_q;
    logic               rx_out_vld;
    logic               rx_out_free;
    logic               rx_lo_beat;
    logic               rx_fire;
    logic               rx_load;
    logic [W-1:0]       rx_word;

    assign rx_out_free = !rx_out_vld | user_upstream_ready;
    assign rx_lo_beat  = !m_gen2_mode & (rx_state == RX_LO);
    assign rxfifo_upstream_ready = rx_lo_beat | rx_out_free;
    assign rx_fire = rxfifo_upstream_valid & rxfifo_upstream_ready;
    assign rx_load = rx_fire & !rx_lo_beat;

    // A Gen2 beat arriving in RX_HI is a whole flit; the stale low half is dropped.
    assign rx_word = m_gen2_mode ? rxfifo_upstream_data
                                 : {rxfifo_upstream_data[HI_W-1:0], rx_lo_q};

    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst) begin
            rx_state   <= RX_LO;
            rx_lo_q    <= '0;
            rx_out_q   <= '0;
            rx_out_vld <= 1'b0;
        end else begin
            if (m_gen2_mode)
                rx_state <= RX_LO;
            else if (rx_fire)
                rx_state <= (rx_state == RX_LO) ? RX_HI : RX_LO;
            if (rx_fire & rx_lo_beat)
                rx_lo_q <= rxfifo_upstream_data[HALF_W-1:0];
            if (rx_load) begin
                rx_out_q   <= rx_word;
                rx_out_vld <= 1'b1;
            end else if (user_upstream_ready) begin
                rx_out_vld <= 1'b0;
            end
        end
    end

    assign user_upstream_valid = rx_out_vld;
    assign ustrm_state  = rx_out_q[3:0];
    assign ustrm_protid = rx_out_q[5:4];
    assign ustrm_data   = rx_out_q[DATA_LSB +: 8*DATA_BYTES];
    assign ustrm_bstart = rx_out_q[BST_LSB +: BSTART_W];
    assign ustrm_bvalid = rx_out_q[BV_LSB +: DATA_BYTES];
    assign ustrm_valid  = rx_out_q[W-1];

`ifdef LPIF_TXRX_PARITY_EN
    assign txfifo_downstream_par = ^txfifo_downstream_data;

    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst)
            rx_parity_err <= 1'b0;
        else if (rx_fire & (^{rxfifo_upstream_data, rxfifo_upstream_par}))
            rx_parity_err <= 1'b1;
    end
`endif

endmodule
